linebuf_win_ctrl: RTL and testbench

//  Sequencer for the 2-line shift register (taps at H and 2H pixels) feeding 3x3 video filters.

---
 rtl/linebuf_win_ctrl_if.sv | 42 ++++
 rtl/linebuf_win_ctrl.sv | 168 ++++++++++++++++
 tb/tb_linebuf_win_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/linebuf_win_ctrl_if.sv
// Signal bundle between the line-buffer window sequencer, its raster source,
// the external 2-line shift register and the downstream 3x3 filter.
interface linebuf_win_ctrl_if #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
);
    localparam int XW = $clog2(IMG_HDISP) + 1;
    localparam int YW = $clog2(IMG_VDISP) + 1;

    logic          in_vsync;
    logic          in_href;
    logic          in_clken;
    logic [7:0]    in_data;

    logic          sr_ce;
    logic [7:0]    sr_shift_in;
    logic [7:0]    sr_taps0x;
    logic [7:0]    sr_taps1x;

    logic          out_clken;
    logic [7:0]    out_row0;
    logic [7:0]    out_row1;
    logic [7:0]    out_row2;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;
    logic          err_ovf;

    modport master (
        output in_vsync, in_href, in_clken, in_data, sr_taps0x, sr_taps1x,
        input  sr_ce, sr_shift_in, out_clken, out_row0, out_row1, out_row2,
        input  out_x, out_y, out_sof, out_eol, out_eof, err_ovf
    );

    modport slave (
        input  in_vsync, in_href, in_clken, in_data, sr_taps0x, sr_taps1x,
        output sr_ce, sr_shift_in, out_clken, out_row0, out_row1, out_row2,
        output out_x, out_y, out_sof, out_eol, out_eof, err_ovf
    );
endinterface

// File: rtl/linebuf_win_ctrl.sv
// Raster sequencer for a 2-line shift register: counts x/y, drives the shift
// enable and aligns pixel + taps into a 3-row column, with a trailing flush line.
module linebuf_win_ctrl #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic               clk,
    input  logic               rst,
    linebuf_win_ctrl_if.slave  bus
);
    localparam int XW = $clog2(IMG_HDISP) + 1;
    localparam int YW = $clog2(IMG_VDISP) + 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_HDISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_VDISP - 1);
    localparam logic [YW-1:0] Y_END  = YW'(IMG_VDISP);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t        state, state_nxt, state_eff;
    logic          vsync_d, vs_edge, pix;
    logic [XW-1:0] x_cnt, x_eff, x_nxt;
    logic [YW-1:0] y_cnt, y_eff, y_nxt;
    logic          line_done, line_done_eff, line_done_nxt;
    logic          err_q, err_nxt, ovf_hit;

    logic          sr_ce_c;
    logic [7:0]    sr_shift_c;
    logic          col_valid, col_sof, col_eol, col_eof;
    logic [7:0]    col_row0, col_row1, col_row2;
    logic [YW-1:0] col_y;

    logic          clken_q, sof_q, eol_q, eof_q;
    logic [7:0]    row0_q, row1_q, row2_q;
    logic [XW-1:0] ox_q;
    logic [YW-1:0] oy_q;

    // A vsync edge overrides everything this cycle: the frame restarts at x=0,y=0
    // and a pixel arriving with the edge already belongs to the new frame.
    assign vs_edge       = bus.in_vsync & ~vsync_d;
    assign pix           = bus.in_href & bus.in_clken;
    assign state_eff     = vs_edge ? FILL : state;
    assign x_eff         = vs_edge ? '0 : x_cnt;
    assign y_eff         = vs_edge ? '0 : y_cnt;
    assign line_done_eff = vs_edge ? 1'b0 : line_done;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state_eff;
        case (state_eff)
            IDLE:    state_nxt = IDLE;
            FILL:    if (sr_ce_c && x_eff == X_LAST)
                         state_nxt = (IMG_VDISP == 1) ? FLUSH : RUN;
            RUN:     if (sr_ce_c && x_eff == X_LAST && y_eff == Y_LAST)
                         state_nxt = FLUSH;
            FLUSH:   if (x_eff == X_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // line_done marks a completed line while href is still high; further
    // pixels on that line are overflow and must not reach the shift register.
    always_comb begin
        sr_ce_c    = 1'b0;
        sr_shift_c = bus.in_data;
        ovf_hit    = 1'b0;
        col_valid  = 1'b0;
        col_row0   = '0;
        col_row1   = bus.sr_taps0x;
        col_row2   = bus.in_data;
        col_y      = y_eff - Y_ONE;
        case (state_eff)
            IDLE: ovf_hit = pix & (y_eff == Y_END);
            FILL: begin
                sr_ce_c = pix & ~line_done_eff;
                ovf_hit = pix & line_done_eff;
            end
            RUN: begin
                sr_ce_c   = pix & ~line_done_eff;
                ovf_hit   = pix & line_done_eff;
                col_valid = sr_ce_c;
                col_row0  = (y_eff == Y_ONE) ? 8'h00 : bus.sr_taps1x;
            end
            FLUSH: begin
                sr_ce_c    = 1'b1;
                sr_shift_c = 8'h00;
                col_valid  = 1'b1;
                col_row0   = (IMG_VDISP == 1) ? 8'h00 : bus.sr_taps1x;
                col_row2   = 8'h00;
                col_y      = Y_LAST;
            end
            default: sr_ce_c = 1'b0;
        endcase
        if (rst) sr_ce_c = 1'b0;
        col_sof = col_valid && x_eff == '0 && col_y == '0;
        col_eol = col_valid && x_eff == X_LAST;
        col_eof = col_eol && col_y == Y_LAST;
    end

    always_comb begin
        x_nxt         = x_eff;
        y_nxt         = y_eff;
        line_done_nxt = line_done_eff & bus.in_href;
        err_nxt       = (err_q & ~vs_edge) | ovf_hit;
        if (sr_ce_c) begin
            if (x_eff == X_LAST) begin
                x_nxt         = '0;
                line_done_nxt = bus.in_href;
                if (y_eff != Y_END) y_nxt = y_eff + Y_ONE;
            end else begin
                x_nxt = x_eff + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d   <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            line_done <= 1'b0;
            err_q     <= 1'b0;
            clken_q   <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
            row0_q    <= '0;
            row1_q    <= '0;
            row2_q    <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
        end else begin
            vsync_d   <= bus.in_vsync;
            x_cnt     <= x_nxt;
            y_cnt     <= y_nxt;
            line_done <= line_done_nxt;
            err_q     <= err_nxt;
            clken_q   <= col_valid;
            sof_q     <= col_sof;
            eol_q     <= col_eol;
            eof_q     <= col_eof;
            if (col_valid) begin
                row0_q <= col_row0;
                row1_q <= col_row1;
                row2_q <= col_row2;
                ox_q   <= x_eff;
                oy_q   <= col_y;
            end
        end
    end

    assign bus.sr_ce       = sr_ce_c;
    assign bus.sr_shift_in = sr_shift_c;
    assign bus.out_clken   = clken_q;
    assign bus.out_row0    = row0_q;
    assign bus.out_row1    = row1_q;
    assign bus.out_row2    = row2_q;
    assign bus.out_x       = ox_q;
    assign bus.out_y       = oy_q;
    assign bus.out_sof     = sof_q;
    assign bus.out_eol     = eol_q;
    assign bus.out_eof     = eof_q;
    assign bus.err_ovf     = err_q;
endmodule

// File: tb/tb_linebuf_win_ctrl.sv
// Randomized bench for linebuf_win_ctrl: frames are generated as images and the
// expected 3-row columns are derived directly from the image (rows y-1, y, y+1).
module tb_linebuf_win_ctrl;
    localparam int H = 8;
    localparam int V = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    linebuf_win_ctrl_if #(.IMG_HDISP(H), .IMG_VDISP(V)) bus ();
    linebuf_win_ctrl #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (.clk(clk), .rst(rst), .bus(bus));

    // External 2H-deep shift register; taps read before the shift.
    logic [7:0] sr_mem [2*H];
    always @(posedge clk) begin
        if (bus.sr_ce) begin
            for (int i = 2*H-1; i > 0; i--) sr_mem[i] <= sr_mem[i-1];
            sr_mem[0] <= bus.sr_shift_in;
        end
    end
    assign bus.sr_taps0x = sr_mem[H-1];
    assign bus.sr_taps1x = sr_mem[2*H-1];

    typedef struct {
        int         due;
        logic [7:0] r0, r1, r2;
        int         x, y;
        bit         sof, eol, eof;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    bit   exp_err = 1'b0;
    bit   prev_vs = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Schedule one output column for the cycle after the current drive.
    task automatic expectColumn(input int x, input int y, input logic [7:0] r0, input logic [7:0] r1,
                                input logic [7:0] r2);
        exp_t e;
        e.due = cyc + 1;
        e.r0  = r0;
        e.r1  = r1;
        e.r2  = r2;
        e.x   = x;
        e.y   = y;
        e.sof = (x == 0 && y == 0);
        e.eol = (x == H-1);
        e.eof = (x == H-1 && y == V-1);
        exp_q.push_back(e);
    endtask

    task automatic checkCycle();
        exp_t e;
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            checkOutput("out_clken", 32'(bus.out_clken), 1);
            checkOutput("out_row0",  32'(bus.out_row0),  32'(e.r0));
            checkOutput("out_row1",  32'(bus.out_row1),  32'(e.r1));
            checkOutput("out_row2",  32'(bus.out_row2),  32'(e.r2));
            checkOutput("out_x",     32'(bus.out_x),     e.x);
            checkOutput("out_y",     32'(bus.out_y),     e.y);
            checkOutput("out_sof",   32'(bus.out_sof),   32'(e.sof));
            checkOutput("out_eol",   32'(bus.out_eol),   32'(e.eol));
            checkOutput("out_eof",   32'(bus.out_eof),   32'(e.eof));
        end else begin
            checkOutput("idle_clken", 32'(bus.out_clken), 0);
            checkOutput("idle_sof",   32'(bus.out_sof),   0);
            checkOutput("idle_eol",   32'(bus.out_eol),   0);
            checkOutput("idle_eof",   32'(bus.out_eof),   0);
        end
        checkOutput("err_ovf", 32'(bus.err_ovf), 32'(exp_err));
    endtask

    // Drive one clock cycle of input, check the combinational shift controls,
    // then check the registered outputs just after the edge.
    task automatic applyStimulus(input bit vs, input bit href, input bit clken, input logic [7:0] data,
                                 input bit exp_ce, input logic [7:0] exp_sin, input bit ovf);
        bus.in_vsync = vs;
        bus.in_href  = href;
        bus.in_clken = clken;
        bus.in_data  = data;
        #1;
        checkOutput("sr_ce", 32'(bus.sr_ce), 32'(exp_ce));
        if (exp_ce) checkOutput("sr_shift_in", 32'(bus.sr_shift_in), 32'(exp_sin));
        if (vs && !prev_vs) exp_err = 1'b0;
        if (ovf) exp_err = 1'b1;
        prev_vs = vs;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        checkCycle();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b0, 8'h00, 1'b0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_clken", 32'(bus.out_clken), 0);
        checkOutput("rst_row0",  32'(bus.out_row0),  0);
        checkOutput("rst_row1",  32'(bus.out_row1),  0);
        checkOutput("rst_row2",  32'(bus.out_row2),  0);
        checkOutput("rst_x",     32'(bus.out_x),     0);
        checkOutput("rst_y",     32'(bus.out_y),     0);
        checkOutput("rst_eof",   32'(bus.out_eof),   0);
        checkOutput("rst_err",   32'(bus.err_ovf),   0);
        checkOutput("rst_sr_ce", 32'(bus.sr_ce),     0);
    endtask

    task automatic applyReset();
        exp_q.delete();
        exp_err = 1'b0;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        checkResetState();
    endtask

    // One frame. abort_row >= 0 stops mid-row (at x=3) of that row; extra_row >= 0
    // sends a 9th pixel on that line; rst_flush resets during the flush line.
    task automatic sendFrame(input bit pattern, input bit throttle, input bit edge_pix,
                             input int abort_row, input int extra_row, input bit rst_flush);
        logic [7:0] img [V][H];
        bit         vs;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                img[y][x] = pattern ? 8'(16*y + x) : 8'($urandom);

        if (!edge_pix) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            idleCycles($urandom_range(1, 3));
        end

        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (y == abort_row && x == 3) return;
                if (throttle)
                    repeat ($urandom_range(0, 2))
                        applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom), 1'b0, 8'h00, 1'b0);
                vs = edge_pix && y == 0 && x == 0;
                if (y >= 1)
                    expectColumn(x, y-1, (y == 1) ? 8'h00 : img[y-2][x], img[y-1][x], img[y][x]);
                applyStimulus(vs, 1'b1, 1'b1, img[y][x], 1'b1, img[y][x], 1'b0);
                if (y == extra_row && x == H-1)
                    applyStimulus(1'b0, 1'b1, 1'b1, 8'($urandom), 1'b0, 8'h00, 1'b1);
            end
            if (y != V-1) idleCycles($urandom_range(1, 3));
        end

        for (int n = 0; n < H; n++) begin
            if (rst_flush && n == 3) begin
                applyReset();
                return;
            end
            expectColumn(n, V-1, img[V-2][n], img[V-1][n], 8'h00);
            applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b1, 8'h00, 1'b0);
        end
        idleCycles(3);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.in_vsync = 1'b0;
        bus.in_href  = 1'b0;
        bus.in_clken = 1'b0;
        bus.in_data  = 8'h00;
        @(negedge clk);
        applyReset();
        idleCycles(2);

        sendFrame(1'b1, 1'b0, 1'b0, -1, -1, 1'b0);
        sendFrame(1'b1, 1'b1, 1'b0, -1, -1, 1'b0);
        sendFrame(1'b0, 1'b0, 1'b0,  2, -1, 1'b0);
        sendFrame(1'b0, 1'b1, 1'b0, -1, -1, 1'b0);
        // Pixel after the frame and its flush are complete.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'($urandom), 1'b0, 8'h00, 1'b1);
        idleCycles(2);
        sendFrame(1'b0, 1'b1, 1'b1, -1,  1, 1'b0);
        sendFrame(1'b1, 1'b0, 1'b0, -1, -1, 1'b1);
        idleCycles(2);
        sendFrame(1'b1, 1'b0, 1'b0, -1, -1, 1'b0);
        for (int f = 0; f < 4; f++)
            sendFrame(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1, 1'b0);

        checkOutput("pending_columns", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
